// File: rtl/fir_da_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_da_ctrl_if
// Brief    : Handshake and datapath-enable bundle of the DA FIR controller.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_da_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W)
);
    logic             i_flush;
    logic             i_in_valid;
    logic             o_in_ready;
    logic             o_load;
    logic             o_acc_clr;
    logic             o_shift_en;
    logic             o_acc_en;
    logic             o_acc_sub;
    logic [CNT_W-1:0] o_bit_idx;
    logic             o_cap_en;
    logic             o_out_valid;
    logic             o_busy;

    // Upstream source plus datapath side of the bundle.
    modport master (
        output i_flush, i_in_valid,
        input  o_in_ready, o_load, o_acc_clr, o_shift_en, o_acc_en,
               o_acc_sub, o_bit_idx, o_cap_en, o_out_valid, o_busy
    );

    // Controller side of the bundle.
    modport slave (
        input  i_flush, i_in_valid,
        output o_in_ready, o_load, o_acc_clr, o_shift_en, o_acc_en,
               o_acc_sub, o_bit_idx, o_cap_en, o_out_valid, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/fir_da_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_da_ctrl
// Brief    : Load / bit-serial run / capture sequencer for a DA FIR datapath.
// Revision : 1.0 - initial release
// ============================================================================
module fir_da_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    fir_da_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_bit_idx;
    logic [CNT_W-1:0] w_bit_idx_nxt;
    logic             w_last;

    logic w_in_ready;
    logic w_load;
    logic w_shift;
    logic w_done;
    logic w_acc_sub;

    assign w_last = (r_bit_idx == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    // Next state; the bit counter is only ever nonzero inside RUN.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_idx_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_in_valid) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_bit_idx_nxt = r_bit_idx + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = bus.i_in_valid ? S_LOAD : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (bus.i_flush) begin
            w_state_nxt   = S_IDLE;
            w_bit_idx_nxt = '0;
        end
    end

    // Outputs depend on registered state only, never on i_in_valid.
    always_comb begin
        w_in_ready = 1'b0;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_done     = 1'b0;
        w_acc_sub  = 1'b0;
        case (r_state)
            S_IDLE: w_in_ready = 1'b1;
            S_LOAD: w_load     = 1'b1;
            S_RUN: begin
                w_shift   = 1'b1;
                w_acc_sub = w_last;
            end
            S_DONE: begin
                w_in_ready = 1'b1;
                w_done     = 1'b1;
            end
            default: w_in_ready = 1'b0;
        endcase
    end

    assign bus.o_in_ready  = w_in_ready;
    assign bus.o_load      = w_load;
    assign bus.o_acc_clr   = w_load;
    assign bus.o_shift_en  = w_shift;
    assign bus.o_acc_en    = w_shift;
    assign bus.o_acc_sub   = w_acc_sub;
    assign bus.o_bit_idx   = r_bit_idx;
    assign bus.o_cap_en    = w_done;
    assign bus.o_out_valid = w_done;
    assign bus.o_busy      = w_load | w_shift;

endmodule
`default_nettype wire

// File: tb/tb_fir_da_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_da_ctrl
// Brief    : Scoreboard bench; a 4-tap DA FIR datapath is driven by the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_da_ctrl;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;
    localparam int H [4]  = '{3, -5, 7, 2};

    typedef struct {
        int cyc;
        int dout;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic signed [DATA_W-1:0] din;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    fir_da_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_if ();

    fir_da_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath: the tap history commits only on capture, so aborted samples leave no trace.
    logic [DATA_W-1:0] sr   [4];
    int                pend [4];
    int                hist [4];
    int                acc;
    int                dout;

    function automatic int rom(input logic [3:0] a);
        int s = 0;
        for (int k = 0; k < 4; k++) if (a[k]) s += H[k];
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                sr[k] <= '0; pend[k] <= 0; hist[k] <= 0;
            end
            acc  <= 0;
            dout <= 0;
        end else begin
            if (u_if.o_load) begin
                sr[0]   <= din;
                pend[0] <= int'(din);
                for (int k = 1; k < 4; k++) begin
                    sr[k]   <= DATA_W'(hist[k-1]);
                    pend[k] <= hist[k-1];
                end
            end else if (u_if.o_shift_en) begin
                for (int k = 0; k < 4; k++) sr[k] <= sr[k] >> 1;
            end
            if (u_if.o_acc_clr) begin
                acc <= 0;
            end else if (u_if.o_acc_en) begin
                if (u_if.o_acc_sub)
                    acc <= acc - rom({sr[3][0], sr[2][0], sr[1][0], sr[0][0]}) * (1 << int'(u_if.o_bit_idx));
                else
                    acc <= acc + rom({sr[3][0], sr[2][0], sr[1][0], sr[0][0]}) * (1 << int'(u_if.o_bit_idx));
            end
            if (u_if.o_cap_en) begin
                dout <= acc;
                for (int k = 0; k < 4; k++) hist[k] <= pend[k];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // st: 0 idle/reset, 1 load, 2 run, 3 done
    function automatic logic [31:0] exp_ctrl(input int st, input int b);
        logic [8:0] f;
        f = '0;
        case (st)
            0: f[8] = 1'b1;
            1: begin f[7] = 1'b1; f[6] = 1'b1; f[0] = 1'b1; end
            2: begin f[5] = 1'b1; f[4] = 1'b1; f[3] = (b == DATA_W-1); f[0] = 1'b1; end
            default: begin f[8] = 1'b1; f[2] = 1'b1; f[1] = 1'b1; end
        endcase
        return {20'd0, f, CNT_W'((st == 2) ? b : 0)};
    endfunction

    function automatic logic [31:0] act_ctrl();
        return {20'd0, u_if.o_in_ready, u_if.o_load, u_if.o_acc_clr, u_if.o_shift_en,
                u_if.o_acc_en, u_if.o_acc_sub, u_if.o_cap_en, u_if.o_out_valid,
                u_if.o_busy, u_if.o_bit_idx};
    endfunction

    // Monitor: pops on each out_valid, checks its cycle, then dout one cycle later.
    logic dout_due = 1'b0;
    int   dout_exp;
    always @(negedge clk) begin
        if (dout_due) begin
            check("dout", dout, dout_exp);
            dout_due = 1'b0;
        end
        if (u_if.o_out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_valid_cycle", cyc, e.cyc);
                dout_exp = e.dout;
                dout_due = 1'b1;
            end
        end
    end

    // Called at a negedge; returns at a negedge after the LOAD edge.
    task automatic send(input int x, input int y, input bit hold, input bit trace);
        int k;
        din = DATA_W'(x);
        u_if.i_in_valid = 1'b1;
        k = 0;
        while (!u_if.o_in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!u_if.o_in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        q.push_back('{cyc: cyc + DATA_W + 2, dout: y});
        @(posedge clk);
        @(negedge clk);
        if (!hold) u_if.i_in_valid = 1'b0;
        if (trace) begin
            check("trace_load", act_ctrl(), exp_ctrl(1, 0));
            for (int b = 0; b < DATA_W; b++) begin
                @(negedge clk);
                check("trace_run", act_ctrl(), exp_ctrl(2, b));
            end
            @(negedge clk);
            check("trace_done", act_ctrl(), exp_ctrl(3, 0));
            if (!hold) begin
                @(negedge clk);
                check("trace_idle", act_ctrl(), exp_ctrl(0, 0));
            end
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic wait_bit(input int b);
        int k = 0;
        while (int'(u_if.o_bit_idx) != b && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("wait_bit_idx", u_if.o_bit_idx, b);
    endtask

    task automatic drain();
        int k = 0;
        while ((q.size() != 0 || dout_due) && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        din = '0;
        u_if.i_flush = 1'b0;
        u_if.i_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("in_reset", act_ctrl(), exp_ctrl(0, 0));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", act_ctrl(), exp_ctrl(0, 0));
        end

        // Impulse: single traced sample, then three back-to-back zeros.
        send(1, 3, 1'b0, 1'b1);
        drain();
        send(0, -5, 1'b1, 1'b0);
        send(0, 7, 1'b1, 1'b0);
        send(0, 2, 1'b0, 1'b0);
        drain();

        // Asynchronous reset in the middle of RUN.
        send(9, 0, 1'b0, 1'b0);
        wait_bit(4);
        #2 rst_n = 1'b0;
        #1 check("async_reset", act_ctrl(), exp_ctrl(0, 0));
        void'(q.pop_back());
        @(negedge clk);
        check("reset_hold", act_ctrl(), exp_ctrl(0, 0));
        rst_n = 1'b1;
        @(negedge clk);
        send(4, 12, 1'b0, 1'b1);
        drain();

        // Flush at bit 2 with in_valid still high; next sample loads right after.
        send(5, 0, 1'b1, 1'b0);
        wait_bit(2);
        u_if.i_flush = 1'b1;
        din = -8'sd3;
        void'(q.pop_back());
        @(negedge clk);
        u_if.i_flush = 1'b0;
        check("after_flush", act_ctrl(), exp_ctrl(0, 0));
        send(-3, -29, 1'b1, 1'b0);
        send(-128, -341, 1'b1, 1'b0);
        send(127, 1008, 1'b1, 1'b0);
        send(0, -1537, 1'b0, 1'b0);
        drain();

        repeat (3) @(negedge clk);
        check("final_idle", act_ctrl(), exp_ctrl(0, 0));
        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
